// File: rtl/robot_nav_grid.sv
// Command-driven navigation unit for the grid robot: heading control and
// multi-step forward motion on a bounded GRID_W x GRID_H grid.
module robot_nav_grid #(
    parameter int          GRID_W    = 8,
    parameter int          GRID_H    = 8,
    parameter int          STEP_W    = 4,
    parameter int          START_X   = 0,
    parameter int          START_Y   = 0,
    parameter logic [2:0]  START_DIR = 3'b001
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [STEP_W-1:0]           cmd_steps,
    output logic [2:0]                  orientacao,
    output logic [$clog2(GRID_W)-1:0]   pos_x,
    output logic [$clog2(GRID_H)-1:0]   pos_y,
    output logic [2:0]                  acao,
    output logic [STEP_W-1:0]           steps_left,
    output logic                        busy,
    output logic                        done,
    output logic                        bump
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    localparam logic [2:0] DIR_N = 3'b001;
    localparam logic [2:0] DIR_W = 3'b010;
    localparam logic [2:0] DIR_E = 3'b011;
    localparam logic [2:0] DIR_S = 3'b100;

    typedef enum logic [1:0] {IDLE, TURN, MOVE, DONE} state_t;
    typedef enum logic [1:0] {OP_FWD, OP_LEFT, OP_RIGHT, OP_AROUND} op_t;

    state_t              state, state_next;
    op_t                 op_q, op_next;
    logic                bump_q, bump_next;
    logic [2:0]          dir_next, acao_next;
    logic [XW-1:0]       x_next;
    logic [YW-1:0]       y_next;
    logic [STEP_W-1:0]   steps_next;
    logic                at_edge;

    // An illegal heading code always resolves to North, whatever the turn.
    function automatic logic [2:0] turn_dir(input logic [2:0] d, input op_t op);
        logic [2:0] r;
        r = DIR_N;
        case (op)
            OP_LEFT:   case (d) DIR_N: r = DIR_W; DIR_W: r = DIR_S; DIR_S: r = DIR_E; default: r = DIR_N; endcase
            OP_RIGHT:  case (d) DIR_N: r = DIR_E; DIR_E: r = DIR_S; DIR_S: r = DIR_W; default: r = DIR_N; endcase
            OP_AROUND: case (d) DIR_N: r = DIR_S; DIR_S: r = DIR_N; DIR_W: r = DIR_E; DIR_E: r = DIR_W; default: r = DIR_N; endcase
            default:   r = (d == DIR_W || d == DIR_E || d == DIR_S) ? d : DIR_N;
        endcase
        return r;
    endfunction

    always_comb begin
        case (orientacao)
            DIR_N:   at_edge = (pos_y == Y_MAX);
            DIR_S:   at_edge = (pos_y == '0);
            DIR_E:   at_edge = (pos_x == X_MAX);
            DIR_W:   at_edge = (pos_x == '0);
            default: at_edge = 1'b1;
        endcase
    end

    // NOTE: every next-state variable gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        op_next    = op_q;
        bump_next  = bump_q;
        dir_next   = orientacao;
        x_next     = pos_x;
        y_next     = pos_y;
        steps_next = steps_left;
        acao_next  = 3'b000;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_next = op_t'(cmd_op);
                    if (op_t'(cmd_op) == OP_FWD) begin
                        steps_next = cmd_steps;
                        state_next = MOVE;
                    end else begin
                        state_next = TURN;
                    end
                end
            end
            TURN: begin
                dir_next   = turn_dir(orientacao, op_q);
                state_next = DONE;
            end
            MOVE: begin
                if (steps_left == '0) begin
                    state_next = DONE;
                end else if (at_edge) begin
                    bump_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    case (orientacao)
                        DIR_N:   y_next = pos_y + YW'(1);
                        DIR_S:   y_next = pos_y - YW'(1);
                        DIR_E:   x_next = pos_x + XW'(1);
                        default: x_next = pos_x - XW'(1);
                    endcase
                    steps_next = steps_left - STEP_W'(1);
                    acao_next  = orientacao;
                end
            end
            default: begin
                bump_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: reset sits in the sensitivity list so it clears state without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= OP_FWD;
            bump_q     <= 1'b0;
            orientacao <= START_DIR;
            pos_x      <= XW'(START_X);
            pos_y      <= YW'(START_Y);
            steps_left <= '0;
            acao       <= 3'b000;
        end else begin
            state      <= state_next;
            op_q       <= op_next;
            bump_q     <= bump_next;
            orientacao <= dir_next;
            pos_x      <= x_next;
            pos_y      <= y_next;
            steps_left <= steps_next;
            acao       <= acao_next;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign bump      = (state == DONE) && bump_q;

endmodule

// File: tb/tb_robot_nav_grid.sv
// Randomised self-checking bench for robot_nav_grid against a heading-angle /
// coordinate reference model of the robot.
module tb_robot_nav_grid;

    localparam int GRID_W = 8;
    localparam int GRID_H = 8;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_steps;
    logic [2:0]        orientacao;
    logic [2:0]        pos_x;
    logic [2:0]        pos_y;
    logic [2:0]        acao;
    logic [STEP_W-1:0] steps_left;
    logic              busy;
    logic              done;
    logic              bump;

    robot_nav_grid #(.GRID_W(GRID_W), .GRID_H(GRID_H), .STEP_W(STEP_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_steps(cmd_steps), .orientacao(orientacao),
        .pos_x(pos_x), .pos_y(pos_y), .acao(acao), .steps_left(steps_left),
        .busy(busy), .done(done), .bump(bump)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: heading as a counter-clockwise quarter-turn index (0=N,1=W,2=S,3=E).
    int         m_ang, m_x, m_y;
    logic [2:0] code_of [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_bump"},  bump, 0);
        check({tag, "_acao"},  acao, 0);
        check({tag, "_dir"},   orientacao, code_of[m_ang]);
        check({tag, "_x"},     pos_x, m_x);
        check({tag, "_y"},     pos_y, m_y);
    endtask

    task automatic model_reset();
        m_ang = 0;
        m_x   = 0;
        m_y   = 0;
    endtask

    task automatic do_reset();
        tick();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        model_reset();
        #1;
        check_idle("rst");
        check("rst_steps", steps_left, 0);
        tick();
        reset = 1'b0;
    endtask

    task automatic accept(input logic [1:0] op, input int n);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_steps = STEP_W'(n);
        check("acc_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_turn(input logic [1:0] op);
        int old_ang;
        old_ang = m_ang;
        accept(op, $urandom_range(0, 15));
        check("turn_busy", busy, 1);
        check("turn_done_early", done, 0);
        check("turn_dir_hold", orientacao, code_of[old_ang]);
        case (op)
            2'd1:    m_ang = (m_ang + 1) % 4;
            2'd2:    m_ang = (m_ang + 3) % 4;
            default: m_ang = (m_ang + 2) % 4;
        endcase
        tick();
        check("turn_done", done, 1);
        check("turn_bump", bump, 0);
        check("turn_dir", orientacao, code_of[m_ang]);
        check("turn_x", pos_x, m_x);
        check("turn_y", pos_y, m_y);
        tick();
        check_idle("turn_end");
    endtask

    task automatic run_move(input int n, input bit inject);
        int dx, dy, room, exec_n;
        dx = (m_ang == 3) ? 1 : (m_ang == 1) ? -1 : 0;
        dy = (m_ang == 0) ? 1 : (m_ang == 2) ? -1 : 0;
        case (m_ang)
            0:       room = GRID_H - 1 - m_y;
            1:       room = m_x;
            2:       room = m_y;
            default: room = GRID_W - 1 - m_x;
        endcase
        exec_n = (n < room) ? n : room;
        accept(2'b00, n);
        check("mv_busy", busy, 1);
        check("mv_steps0", steps_left, n);
        check("mv_acao0", acao, 0);
        if (inject) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom_range(1, 3));
            check("mv_not_ready", cmd_ready, 0);
        end
        for (int i = 1; i <= exec_n; i++) begin
            tick();
            cmd_valid = 1'b0;
            m_x += dx;
            m_y += dy;
            check("mv_x", pos_x, m_x);
            check("mv_y", pos_y, m_y);
            check("mv_acao", acao, code_of[m_ang]);
            check("mv_steps", steps_left, n - i);
            check("mv_done_early", done, 0);
        end
        tick();
        cmd_valid = 1'b0;
        check("mv_done", done, 1);
        check("mv_bump", bump, (exec_n < n) ? 1 : 0);
        check("mv_left", steps_left, n - exec_n);
        check("mv_acao_end", acao, 0);
        check("mv_x_end", pos_x, m_x);
        check("mv_y_end", pos_y, m_y);
        tick();
        check_idle("mv_end");
    endtask

    initial begin
        code_of[0] = 3'b001;
        code_of[1] = 3'b010;
        code_of[2] = 3'b100;
        code_of[3] = 3'b011;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_steps  = '0;
        model_reset();

        do_reset();

        // Directed: four lefts, right, around, then around from North.
        for (int i = 0; i < 4; i++) run_turn(2'd1);
        run_turn(2'd2);
        run_turn(2'd3);
        do_reset();
        run_turn(2'd3);

        // Directed motion and edge blocking.
        do_reset();
        run_move(3, 1'b0);
        run_turn(2'd3);
        run_move(1, 1'b0);
        run_turn(2'd2);
        run_move(2, 1'b0);
        run_turn(2'd3);
        run_move(9, 1'b0);
        run_move(0, 1'b0);

        // Reset in the middle of a move, with an ignored command pulse.
        do_reset();
        accept(2'b00, 5);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid_y2", pos_y, 2);
        check("mid_dir", orientacao, 3'b001);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_idle("mid_rst");
        check("mid_rst_steps", steps_left, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("mid_after");
        end

        // Randomised command stream.
        for (int k = 0; k < 150; k++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op == 0) run_move($urandom_range(0, 15), $urandom_range(0, 3) == 0);
            else         run_turn(2'(op));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                tick();
                check_idle("gap");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
